// File: rtl/apb_gpio_arbiter_if.sv
// Bundle for the two requester ports, the shared APB port and busy.
// master: the arbiter side; slave: requesters plus APB completer.
interface apb_gpio_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_write;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m0_err;

  logic          m1_req;
  logic          m1_write;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic          m1_err;

  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  logic          busy;

  modport master (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    output m1_ack, m1_rdata, m1_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready,
    output busy
  );

  modport slave (
    output m0_req, m0_write, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_write, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata, m1_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready,
    input  busy
  );
endinterface

// File: rtl/apb_gpio_arbiter.sv
// Round-robin two-requester APB master for the GPIO controller port.
// Every output is a flop; a stalled ACCESS ends in an error response.
module apb_gpio_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic              pclk,
  input logic              preset,
  apb_gpio_arbiter_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lg_q, lg_d;
  logic          gnt_q, gnt_d;

  logic          psel_q, psel_d;
  logic          pen_q, pen_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          busy_q, busy_d;

  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;

  logic          any_req;
  logic          pick;
  logic          fin;
  logic          tout;
  logic [DW-1:0] rd_v;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lg_d     = lg_q;
    gnt_d    = gnt_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    any_req  = bus.m0_req | bus.m1_req;
    pick     = 1'b0;
    fin      = 1'b0;
    tout     = 1'b0;
    rd_v     = '0;

    // on contention the requester that did not win last time goes next
    if (bus.m0_req && bus.m1_req) begin
      pick = ~lg_q;
    end else begin
      pick = bus.m1_req;
    end

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          lg_d    = pick;
          psel_d  = 1'b1;
          pen_d   = 1'b0;
          state_d = SETUP;
          if (pick) begin
            pwrite_d = bus.m1_write;
            paddr_d  = bus.m1_addr;
            pwdata_d = bus.m1_wdata;
          end else begin
            pwrite_d = bus.m0_write;
            paddr_d  = bus.m0_addr;
            pwdata_d = bus.m0_wdata;
          end
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          fin = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fin  = 1'b1;
          tout = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (fin) begin
          state_d = DONE;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          cnt_d   = '0;
          if (!tout && !pwrite_q) begin
            rd_v = bus.prdata;
          end
          if (gnt_q) begin
            ack1_d = 1'b1;
            err1_d = tout;
            rd1_d  = rd_v;
          end else begin
            ack0_d = 1'b1;
            err0_d = tout;
            rd0_d  = rd_v;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lg_q     <= 1'b1;
      gnt_q    <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lg_q     <= lg_d;
      gnt_q    <= gnt_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  assign bus.psel     = psel_q;
  assign bus.penable  = pen_q;
  assign bus.pwrite   = pwrite_q;
  assign bus.paddr    = paddr_q;
  assign bus.pwdata   = pwdata_q;
  assign bus.busy     = busy_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m0_err   = err0_q;
  assign bus.m0_rdata = rd0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m1_err   = err1_q;
  assign bus.m1_rdata = rd1_q;

endmodule

// File: doc/apb_gpio_arbiter.md
Name: apb_gpio_arbiter

Overview:
- Two-requester APB master that shares the single APB port of the GPIO controller.
- Requester 0 is the CPU-side bridge; requester 1 is the aux/test sequencer.
- Round-robin arbitration serialises transfers through the standard APB SETUP/ACCESS phases.
- A PREADY timeout terminates stalled transfers with an error response.

Parameters:
- AW, 32, address width of the command and APB address buses.
- DW, 32, data width of wdata/rdata/pwdata/prdata.
- TIMEOUT, 16, maximum ACCESS-phase cycles waiting for pready before forcing an error response (≥1).

Ports:
- pclk  in  1  single clock for all logic.
- preset  in  1  synchronous active-high reset.
- m0_req  in  1  requester 0 command valid; held until m0_ack.
- m0_write  in  1  1=write, 0=read.
- m0_addr  in  AW  target register address.
- m0_wdata  in  DW  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DW  read data, valid while m0_ack=1.
- m0_err  out  1  timeout flag, valid while m0_ack=1.
- m1_req, m1_write, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err  same as the m0 set, for requester 1.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- prdata  in  DW  APB read data.
- pready  in  1  APB ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, pclk. Reset preset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - FSM in IDLE.
  - psel, penable, pwrite, busy, m0_ack, m1_ack, m0_err, m1_err = 0.
  - paddr, pwdata, m0_rdata, m1_rdata = 0.
  - Wait counter = 0.
  - last_grant = 1, so m0 wins the first contention.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req is high, grant one requester.
  - Latch its write/addr/wdata into pwrite/paddr/pwdata and record the grant. Go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration:
  - If only one req is high, grant it.
  - If both are high, grant the requester not equal to last_grant, then update last_grant to the granted requester.
- SETUP: psel=1, penable=0. Lasts exactly one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1. The wait counter increments each cycle pready=0.
  - pready=1 sampled: go to DONE. For a read, capture prdata into the granted rdata; for a write, rdata=0. err=0.
  - Counter reaches TIMEOUT with pready still 0: go to DONE with err=1 and rdata=0.
- DONE:
  - psel=0, penable=0.
  - Granted ack=1 for exactly this cycle, with its rdata/err. The non-granted ack stays 0.
  - Wait counter clears. Next state is IDLE.
- Requester rule: deassert req (or present a new command) in the cycle after ack. The arbiter never re-samples req in DONE.
- Latency:
  - Req seen in IDLE at cycle N: SETUP at N+1, ACCESS at N+2.
  - pready=1 at N+2: ack at N+3, IDLE at N+4.
  - Minimum is 4 cycles per transfer; each pready wait state adds 1 cycle.
- APB stability: paddr, pwrite and pwdata are held constant from SETUP through the end of ACCESS. They retain their last value in DONE/IDLE and are not zeroed.
- Requester commands are ignored while not granted. Non-granted req may change freely.
- Reset mid-transfer:
  - Immediate return to IDLE, psel/penable drop in the next cycle, no ack is issued.
  - last_grant returns to 1.
- TIMEOUT boundary: exactly TIMEOUT ACCESS cycles with pready=0 gives the error. pready=1 on the TIMEOUT-th cycle itself completes normally with err=0.

Test Plan:
- m0 write: addr=0x04, wdata=0xA5A5_0F0F, pready tied high.
  - Expect psel at N+1, penable at N+2, m0_ack at N+3.
  - pwdata=0xA5A5_0F0F throughout the transfer, m0_err=0, m1_ack never asserted.
- m1 read: addr=0x00, slave returns prdata=0x1234_5678 after 3 wait states.
  - Expect m1_ack at N+6 with m1_rdata=0x1234_5678.
  - paddr stable at 0x00 from N+1 to N+5.
- m0 and m1 both request continuously for 4 transfers each.
  - Grant order must be m0, m1, m0, m1, …
  - Each transfer is 4 cycles; no APB phase overlaps.
- pready held 0 with TIMEOUT=16.
  - After 16 ACCESS cycles, DONE pulses m0_ack with m0_err=1 and m0_rdata=0, then returns to IDLE.
  - A pready=1 on the 16th cycle instead yields err=0.
- preset asserted during ACCESS of an m1 read.
  - Next cycle: psel=0, penable=0, busy=0, no ack.
  - Both reqs then high: m0 granted first.
- Single m0 request held high through ack.
  - Exactly one ack pulse.
  - If req stays high a further cycle after ack, a second transfer starts from IDLE at N+4 (documents the requester rule).
